// File: rtl/sum_pkg.sv
// Shared types and width helpers for the sum_accum packet-sum accumulator.
package sum_pkg;

  typedef enum logic {
    ACCUM = 1'b0,
    HOLD  = 1'b1
  } state_t;

  // Width needed to hold the exact sum of all lanes of one beat.
  function automatic int unsigned tree_width(input int unsigned width,
                                             input int unsigned lanes);
    return width + int'($clog2(lanes));
  endfunction

endpackage

// File: rtl/sum_tree.sv
// Combinational pairwise adder tree: exact sum of LANES unsigned lanes.
module sum_tree
  import sum_pkg::*;
#(
  parameter int unsigned LANES = 16,
  parameter int unsigned WIDTH = 16
) (
  input  logic [LANES*WIDTH-1:0]              in_data,
  output logic [tree_width(WIDTH, LANES)-1:0] sum
);

  localparam int unsigned SUM_W  = tree_width(WIDTH, LANES);
  localparam int unsigned LEVELS = $clog2(LANES);

  // Level 0 holds the zero-extended lanes; each further level halves the count.
  for (genvar l = 0; l <= LEVELS; l++) begin : g_lvl
    localparam int unsigned N = LANES >> l;
    logic [SUM_W-1:0] v [N];

    if (l == 0) begin : g_leaf
      for (genvar i = 0; i < N; i++) begin : g_lane
        assign v[i] = SUM_W'(in_data[i*WIDTH +: WIDTH]);
      end
    end else begin : g_add
      for (genvar i = 0; i < N; i++) begin : g_pair
        assign v[i] = g_lvl[l-1].v[2*i] + g_lvl[l-1].v[2*i+1];
      end
    end
  end

  assign sum = g_lvl[LEVELS].v[0];

endmodule

// File: rtl/sum_accum.sv
// Packet-sum accumulator: sums all lanes of every beat of a packet and holds
// the result until consumed. Define SUM_SATURATE_EN to clamp instead of wrap.
module sum_accum
  import sum_pkg::*;
#(
  parameter int unsigned LANES     = 16,
  parameter int unsigned WIDTH     = 16,
  parameter int unsigned ACC_WIDTH = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [LANES*WIDTH-1:0] in_data,
  input  logic                   in_last,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [ACC_WIDTH-1:0]   out_sum,
  output logic                   out_overflow
);

  localparam int unsigned SUM_W = tree_width(WIDTH, LANES);
  localparam int unsigned EXT_W = ((ACC_WIDTH > SUM_W) ? ACC_WIDTH : SUM_W) + 1;

  state_t               state, state_next;
  logic [ACC_WIDTH-1:0] acc_next;
  logic                 ovf_next;
  logic [SUM_W-1:0]     beat_sum;
  logic [EXT_W-1:0]     total;
  logic                 beat_ovf;

  sum_tree #(
    .LANES (LANES),
    .WIDTH (WIDTH)
  ) u_tree (
    .in_data (in_data),
    .sum     (beat_sum)
  );

  // Exact accumulator + beat sum; any bit above ACC_WIDTH means overflow.
  assign total    = EXT_W'(out_sum) + EXT_W'(beat_sum);
  assign beat_ovf = |total[EXT_W-1:ACC_WIDTH];

  always_comb begin
    state_next = state;
    acc_next   = out_sum;
    ovf_next   = out_overflow;
    unique case (state)
      ACCUM: begin
        if (in_valid) begin
          ovf_next = out_overflow | beat_ovf;
`ifdef SUM_SATURATE_EN
          acc_next = beat_ovf ? {ACC_WIDTH{1'b1}} : total[ACC_WIDTH-1:0];
`else
          acc_next = total[ACC_WIDTH-1:0];
`endif
          if (in_last) begin
            state_next = HOLD;
          end
        end
      end
      HOLD: begin
        if (out_ready) begin
          acc_next   = '0;
          ovf_next   = 1'b0;
          state_next = ACCUM;
        end
      end
      default: state_next = ACCUM;
    endcase
  end

  // The accumulator doubles as the result register; it cannot move in HOLD.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= ACCUM;
      out_sum      <= '0;
      out_overflow <= 1'b0;
      in_ready     <= 1'b1;
      out_valid    <= 1'b0;
    end else begin
      state        <= state_next;
      out_sum      <= acc_next;
      out_overflow <= ovf_next;
      in_ready     <= (state_next == ACCUM);
      out_valid    <= (state_next == HOLD);
    end
  end

endmodule

// File: doc/sum_accum.md
SUM_ACCUM -- requirements
Module: sum_accum

Interface
REQ-001 The block SHALL have parameter LANES, default 16, number of unsigned lanes per input beat (power of two, >=2).
REQ-002 The block SHALL have parameter WIDTH, default 16, bits per lane.
REQ-003 The block SHALL have parameter ACC_WIDTH, default 16, bits of the result.
REQ-004 The block SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-005 The block SHALL have port rst, input, 1, reset, synchronous and active-high.
REQ-006 The block SHALL have port in_valid, input, 1, input beat present.
REQ-007 The block SHALL have port in_ready, output, 1, block accepts a beat this cycle.
REQ-008 The block SHALL have port in_data, input, LANES*WIDTH, packed lanes; lane i occupies bits [i*WIDTH +: WIDTH].
REQ-009 The block SHALL have port in_last, input, 1, the beat is the final beat of a packet.
REQ-010 The block SHALL have port out_valid, output, 1, result available.
REQ-011 The block SHALL have port out_ready, input, 1, consumer takes the result.
REQ-012 The block SHALL have port out_sum, output, ACC_WIDTH, packet sum.
REQ-013 The block SHALL have port out_overflow, output, 1, packet sum exceeded 2^ACC_WIDTH-1.

Function
REQ-014 The block SHALL implement a two-state FSM: ACCUM (collecting beats) and HOLD (presenting result).
REQ-015 in_ready SHALL be 1 exactly in ACCUM; out_valid SHALL be 1 exactly in HOLD.
REQ-016 A beat SHALL be accepted when in_valid && in_ready; the lane sum is computed at full precision (WIDTH+log2(LANES) bits) and added to the accumulator on that edge.
REQ-017 Accumulation SHALL be unsigned; overflow SHALL be detected against 2^ACC_WIDTH-1 at each accepted beat and held sticky for the packet.
REQ-018 An accepted beat with in_last=1 SHALL move ACCUM->HOLD; out_sum/out_overflow SHALL be valid the next cycle (latency 1 from last beat).
REQ-019 out_sum and out_overflow SHALL remain stable while out_valid=1 and out_ready=0.
REQ-020 On out_valid && out_ready the block SHALL clear accumulator and overflow and return to ACCUM; the next beat is acceptable the following cycle.
REQ-021 Beats with in_valid=0 SHALL leave state unchanged; a packet may have any number of beats >=1.
REQ-022 in_data/in_last SHALL be ignored whenever in_ready=0.

Reset
REQ-023 rst=1 at a clock edge SHALL force ACCUM, accumulator=0, out_sum=0, out_overflow=0, out_valid=0, in_ready=1 after the edge.
REQ-024 rst SHALL take priority over any simultaneous handshake; a partial or held packet is discarded.

Configuration
REQ-025 Macro SUM_SATURATE_EN SHALL select overflow handling.
REQ-026 With SUM_SATURATE_EN defined, an overflowing accumulator SHALL clamp to 2^ACC_WIDTH-1 and stay there for the rest of the packet.
REQ-027 Without SUM_SATURATE_EN, the accumulator SHALL wrap modulo 2^ACC_WIDTH; out_overflow behaves identically in both builds.

Structure
REQ-028 Package sum_pkg SHALL hold the FSM state enum and a clog2-derived tree-width constant function.
REQ-029 Sub-module sum_tree (combinational pairwise adder tree, parameters LANES, WIDTH) SHALL produce the full-precision lane sum.
REQ-030 Expected size SHALL be 120-400 lines RTL total.

Verification (defaults LANES=16, WIDTH=16, ACC_WIDTH=16)
REQ-031 Single beat, lane0=2, lane1=3, rest 0, in_last=1 -> next cycle out_valid=1, out_sum=0x0005, out_overflow=0.
REQ-032 Three beats, all lanes 0x0001, last on third -> out_sum=0x0030 one cycle after third beat; in_ready=0 during HOLD.
REQ-033 Single beat, all lanes 0xFFFF (full sum 0xFFFF0) -> out_overflow=1; out_sum=0xFFF0 without macro, 0xFFFF with SUM_SATURATE_EN.
REQ-034 Result held with out_ready=0 for 5 cycles -> out_sum stable, in_ready=0; out_ready=1 -> out_valid=0 next cycle, next packet (all lanes 0x0010) yields 0x0100.
REQ-035 Two beats of all 0x0001 then rst before last -> all outputs reset; next single beat all 0x0001 with in_last -> out_sum=0x0010.
REQ-036 in_valid gaps between beats of a packet -> sum identical to gap-free case.
